// File: rtl/if_data_serializer.sv
// rtl/if_data_serializer.sv - LSB-first parallel-to-serial word producer with frame qualifier
//
// Optional odd-parity trailer bit: define IF_DATA_SERIALIZER_PARITY_EN.
// Every output is a flop, so the downstream consumer never sees a combinational
// path from in_valid or in_word.

module if_data_serializer #(
    parameter int FOO        = 5,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [FOO-1:0] in_word,
    output logic           data,
    output logic           frame,
    output logic           frame_done,
    output logic           busy
);

    // Bit counter is wide enough to hold FOO-1; FOO=1 still needs a 1-bit counter.
    localparam int CW = (FOO > 1) ? $clog2(FOO) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FOO - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef IF_DATA_SERIALIZER_PARITY_EN
        ST_PARITY = 2'd3,
`endif
        ST_GAP    = 2'd2
    } state_t;

    state_t          state_q;
    // Holds the payload bits that have not yet been driven; bit 0 is the next one out.
    logic [FOO-1:0]  shift_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            data_q;
    logic            frame_q;
    logic            frame_done_q;
    logic            busy_q;
`ifdef IF_DATA_SERIALIZER_PARITY_EN
    // Odd parity of the whole word, fixed at capture so later in_word changes cannot leak in.
    logic            par_q;
`endif

    // Frame sequencer: every output is loaded with the value it must show in the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            data_q       <= IDLE_LEVEL;
            frame_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef IF_DATA_SERIALIZER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        // Bit 0 goes straight to the output; the rest wait in shift_q.
                        state_q    <= ST_SHIFT;
                        shift_q    <= in_word >> 1;
                        cnt_q      <= CNT_LOAD;
                        data_q     <= in_word[0];
                        frame_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
`ifdef IF_DATA_SERIALIZER_PARITY_EN
                        par_q      <= ~^in_word;
`endif
                    end else begin
                        in_ready_q <= 1'b1;
                        data_q     <= IDLE_LEVEL;
                        frame_q    <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (cnt_q == '0) begin
`ifdef IF_DATA_SERIALIZER_PARITY_EN
                        state_q      <= ST_PARITY;
                        data_q       <= par_q;
`else
                        state_q      <= ST_GAP;
                        data_q       <= IDLE_LEVEL;
                        frame_q      <= 1'b0;
                        frame_done_q <= 1'b1;
`endif
                    end else begin
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q - CW'(1);
                        data_q  <= shift_q[0];
                    end
                end

`ifdef IF_DATA_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    state_q      <= ST_GAP;
                    data_q       <= IDLE_LEVEL;
                    frame_q      <= 1'b0;
                    frame_done_q <= 1'b1;
                end
`endif

                ST_GAP: begin
                    // The single gap cycle ends here; the block is ready again next cycle.
                    state_q      <= ST_IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    in_ready_q   <= 1'b1;
                    data_q       <= IDLE_LEVEL;
                    frame_q      <= 1'b0;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    in_ready_q   <= 1'b0;
                    data_q       <= IDLE_LEVEL;
                    frame_q      <= 1'b0;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign data       = data_q;
    assign frame      = frame_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: doc/if_data_serializer.md
# if_data_serializer

Parallel-to-serial producer that sits directly upstream of the parameterised interface consumer and drives its 1-bit `data` line. It accepts one FOO-bit word per valid/ready handshake and shifts it out LSB-first, one bit per clock, with a `frame` qualifier. An inter-frame gap cycle separates frames. An optional odd-parity trailer bit can be compiled in. The width parameter uses the same name and default as the consumer's interface parameter, so one value configures both ends.

## Interface

Parameters:
- `FOO`, default 5: payload bits per frame; legal range 1..32.
- `IDLE_LEVEL`, default 0: value driven on `data` whenever `frame` is low.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_word`  in  FOO  payload, sampled only on handshake.
- `data`  out  1  serial bit to the consumer interface.
- `frame`  out  1  high while `data` carries a payload or parity bit.
- `frame_done`  out  1  one-cycle pulse after the last bit of a frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, SHIFT, PARITY (present only with the macro), GAP.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture `in_word` into the shift register, load bit counter = FOO-1, go to SHIFT.
- SHIFT:
  - `data` = shift_reg[0]; `frame` = 1.
  - Each cycle, shift right and decrement the counter.
  - When counter == 0: go to PARITY if enabled, else GAP.
- PARITY: `data` = ~^captured_word (odd parity over the payload); `frame` = 1; go to GAP.
- GAP:
  - `data` = IDLE_LEVEL; `frame` = 0; `frame_done` = 1.
  - Go to IDLE.
- Counter width is max(1, $clog2(FOO)). FOO=1 gives exactly one SHIFT cycle.
- The word is captured in full at the handshake. Later changes to `in_word` have no effect on the current frame.
- `in_valid` low in IDLE: stay in IDLE; `data` = IDLE_LEVEL.
- `in_valid` asserted outside IDLE: ignored. Upstream must hold it until `in_ready` is high.
- All outputs are registered; no combinational path from `in_valid` or `in_word` to any output.

## Timing

- Reset values:
  - state = IDLE
  - `in_ready` = 0
  - `data` = IDLE_LEVEL
  - `frame` = 0
  - `frame_done` = 0
  - `busy` = 0
- `in_ready` rises on the first rising edge after `rst_n` deasserts.
- Handshake at edge k: payload bit i appears on `data` in cycle k+1+i, for i = 0..FOO-1.
- Parity (if enabled) appears in cycle k+1+FOO.
- GAP follows the last bit. `frame_done` is high for that single cycle.
- `in_ready` returns high the cycle after GAP. Minimum frame period is FOO+2 cycles, or FOO+3 with parity.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). The partial frame is discarded, `frame_done` is not pulsed, and no frame resumes after reset.

## Configuration

- `IF_DATA_SERIALIZER_PARITY_EN`:
  - Defined: the PARITY state exists and each frame carries FOO+1 framed bits, the last being odd parity.
  - Undefined: the PARITY state and the parity logic are not compiled. Each frame carries exactly FOO framed bits.

## Test plan

- Reset release: hold `rst_n`=0 for 3 cycles, then release. Required: all outputs at reset values during reset; `in_ready`=1 one edge after release.
- Single frame, FOO=5, no parity: `in_word`=5'b10110 with a one-cycle `in_valid`. Required: `data` = 0,1,1,0,1 with `frame`=1 for 5 cycles; then `frame_done`=1 for 1 cycle; then `in_ready`=1.
- Parity build, same word: required sixth framed bit = 0 (three ones in the payload). With 5'b00011, the sixth bit = 1.
- Back-to-back: hold `in_valid` high with words 5'h1F then 5'h00. Required: the second handshake occurs exactly FOO+2 cycles after the first (FOO+3 with parity); exactly one GAP cycle between frames.
- Word change after capture: change `in_word` to 5'h00 the cycle after accepting 5'h15. Required: serial output is still 1,0,1,0,1.
- Reset mid-frame: assert `rst_n`=0 during the third SHIFT cycle. Required: `frame`=0 and `data`=IDLE_LEVEL at once; no `frame_done`; after release, the next accepted word serialises correctly from bit 0.
